// File: rtl/tiny_processor_pkg.sv
// Shared definitions for the tiny accumulator processor: opcodes, field widths,
// default program ROM and register-file power-on contents.
package tiny_processor_pkg;

  localparam int OPC_W  = 4;
  localparam int ARG_W  = 4;
  localparam int DATA_W = 8;

  localparam logic [3:0] OP_SHIFT = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_MUL   = 4'h3;
  localparam logic [3:0] OP_XOR   = 4'h5;
  localparam logic [3:0] OP_CMP   = 4'h6;
  localparam logic [3:0] OP_AND   = 4'h7;
  localparam logic [3:0] OP_BR    = 4'h8;
  localparam logic [3:0] OP_LDA   = 4'h9;
  localparam logic [3:0] OP_STA   = 4'hA;
  localparam logic [3:0] OP_RET   = 4'hB;

  localparam logic [3:0] SUB_LSL = 4'h1;
  localparam logic [3:0] SUB_LSR = 4'h2;
  localparam logic [3:0] SUB_ROR = 4'h3;
  localparam logic [3:0] SUB_ROL = 4'h4;
  localparam logic [3:0] SUB_ASR = 4'h5;
  localparam logic [3:0] SUB_INC = 4'h6;
  localparam logic [3:0] SUB_DEC = 4'h7;

  localparam logic [7:0] INSTR_HLT = 8'hFF;

  function automatic logic [7:0] rom_default(input logic [3:0] addr);
    case (addr)
      4'd0:    return 8'h93;
      4'd1:    return 8'h15;
      4'd2:    return 8'h1F;
      4'd3:    return 8'h86;
      4'd4:    return 8'hA7;
      4'd5:    return 8'hFF;
      4'd6:    return 8'h11;
      4'd7:    return 8'hB0;
      default: return 8'h00;
    endcase
  endfunction

  // Register i powers up holding its own index in both nibbles.
  function automatic logic [7:0] reg_init(input logic [3:0] idx);
    return {idx, idx};
  endfunction

endpackage

// File: rtl/tiny_alu.sv
// Combinational datapath for opcodes 0000-0111: computes the new accumulator,
// EXT high byte and carry/borrow plus which of them the instruction updates.
module tiny_alu
  import tiny_processor_pkg::*;
(
  input  logic [7:0] acc,
  input  logic [7:0] operand,
  input  logic [3:0] opcode,
  input  logic [3:0] subcode,
  input  logic       cb_in,
  output logic [7:0] result,
  output logic [7:0] ext_hi,
  output logic       cb_new,
  output logic       acc_we,
  output logic       ext_we,
  output logic       cb_we
);

  logic [8:0]  sum;
  logic [15:0] prod;

  always_comb begin
    sum    = 9'h000;
    prod   = 16'h0000;
    result = acc;
    ext_hi = 8'h00;
    cb_new = cb_in;
    acc_we = 1'b0;
    ext_we = 1'b0;
    cb_we  = 1'b0;
    case (opcode)
      OP_SHIFT: begin
        case (subcode)
          SUB_LSL: begin result = {acc[6:0], 1'b0}; acc_we = 1'b1; end
          SUB_LSR: begin result = {1'b0, acc[7:1]}; acc_we = 1'b1; end
          SUB_ROR: begin result = {acc[0], acc[7:1]}; acc_we = 1'b1; end
          SUB_ROL: begin result = {acc[6:0], acc[7]}; acc_we = 1'b1; end
          SUB_ASR: begin result = {acc[7], acc[7:1]}; acc_we = 1'b1; end
          SUB_INC: begin
            sum    = {1'b0, acc} + 9'd1;
            result = sum[7:0];
            cb_new = sum[8];
            acc_we = 1'b1;
            cb_we  = 1'b1;
          end
          // Bit 8 of the 9-bit difference is the borrow out of 0 - 1.
          SUB_DEC: begin
            sum    = {1'b0, acc} - 9'd1;
            result = sum[7:0];
            cb_new = sum[8];
            acc_we = 1'b1;
            cb_we  = 1'b1;
          end
          default: result = acc;
        endcase
      end
      OP_ADD: begin
        sum    = {1'b0, acc} + {1'b0, operand};
        result = sum[7:0];
        cb_new = sum[8];
        acc_we = 1'b1;
        cb_we  = 1'b1;
      end
      OP_SUB: begin
        sum    = {1'b0, acc} - {1'b0, operand};
        result = sum[7:0];
        cb_new = sum[8];
        acc_we = 1'b1;
        cb_we  = 1'b1;
      end
      OP_MUL: begin
        prod   = {8'h00, acc} * {8'h00, operand};
        result = prod[7:0];
        ext_hi = prod[15:8];
        acc_we = 1'b1;
        ext_we = 1'b1;
      end
      OP_XOR: begin result = acc ^ operand; acc_we = 1'b1; end
      OP_AND: begin result = acc & operand; acc_we = 1'b1; end
      OP_CMP: begin cb_new = (acc < operand); cb_we = 1'b1; end
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/tiny_processor.sv
// Single-cycle 8-bit accumulator processor: fixed 16-entry ROM, 16x8 register
// file, CB flag, EXT register and a single return-address register.
module tiny_processor
  import tiny_processor_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] start_address,
  output logic [7:0] acc_out,
  output logic [3:0] pc,
  output logic [7:0] ir_out,
  output logic       alu_enable_out,
  output logic       reg_write_out,
  output logic [7:0] alu_opcode_out,
  output logic [7:0] instruction_out,
  output logic [7:0] result_out,
  output logic [7:0] ext_out,
  output logic [7:0] reg_data_out,
  output logic       cb_out
);

  logic [7:0] acc;
  logic [7:0] ext;
  logic       cb;
  logic [3:0] ret_addr;
  logic [7:0] last_instr;
  logic [7:0] regs [16];

  logic [7:0] ir;
  logic [3:0] opcode;
  logic [3:0] arg;
  logic       halt;
  logic       alu_en;
  logic [3:0] pc_next;
  logic [7:0] alu_result;
  logic [7:0] alu_ext;
  logic       alu_cb;
  logic       alu_acc_we;
  logic       alu_ext_we;
  logic       alu_cb_we;

  assign ir     = rom_default(pc);
  assign opcode = ir[7:4];
  assign arg    = ir[3:0];
  assign halt   = (ir == INSTR_HLT);
  assign alu_en = ~ir[7];

  tiny_alu u_alu (
    .acc     (acc),
    .operand (regs[arg]),
    .opcode  (opcode),
    .subcode (arg),
    .cb_in   (cb),
    .result  (alu_result),
    .ext_hi  (alu_ext),
    .cb_new  (alu_cb),
    .acc_we  (alu_acc_we),
    .ext_we  (alu_ext_we),
    .cb_we   (alu_cb_we)
  );

  // A taken branch and RET are the only redirects; HLT freezes the counter.
  always_comb begin
    pc_next = pc + 4'd1;
    if (halt) begin
      pc_next = pc;
    end else if ((opcode == OP_BR) && cb) begin
      pc_next = arg;
    end else if (opcode == OP_RET) begin
      pc_next = ret_addr;
    end else begin
      pc_next = pc + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc         <= start_address;
      acc        <= 8'h00;
      ext        <= 8'h00;
      cb         <= 1'b0;
      ret_addr   <= 4'h0;
      last_instr <= 8'h00;
      for (int i = 0; i < 16; i++) begin
        regs[i] <= reg_init(4'(i));
      end
    end else if (!halt) begin
      pc         <= pc_next;
      last_instr <= ir;
      if (alu_acc_we) begin
        acc <= alu_result;
      end else if (opcode == OP_LDA) begin
        acc <= regs[arg];
      end
      if (alu_ext_we) begin
        ext <= alu_ext;
      end
      if (alu_cb_we) begin
        cb <= alu_cb;
      end
      if (opcode == OP_STA) begin
        regs[arg] <= acc;
      end
      if ((opcode == OP_BR) && cb) begin
        ret_addr <= pc + 4'd1;
      end
    end
  end

  assign acc_out         = acc;
  assign ext_out         = ext;
  assign cb_out          = cb;
  assign instruction_out = last_instr;
  assign ir_out          = ir;
  assign alu_enable_out  = alu_en;
  assign reg_write_out   = (opcode == OP_STA);
  assign alu_opcode_out  = alu_en ? {4'b0000, opcode} : 8'h00;
  assign result_out      = alu_en ? alu_result : 8'h00;
  assign reg_data_out    = regs[arg];

endmodule

// File: tb/tb_tiny_processor.sv
// Bench for tiny_processor: fixed program trace, halt/reset/wrap sequences,
// ALU vector table and randomized runs against an instruction-level model.
module tb_tiny_processor;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] start_address;
  logic [7:0] acc_out, ir_out, alu_opcode_out, instruction_out, result_out, ext_out, reg_data_out;
  logic [3:0] pc;
  logic       alu_enable_out, reg_write_out, cb_out;

  logic [7:0] t_acc, t_opd, t_res, t_ext;
  logic [3:0] t_op, t_sub;
  logic       t_cbi, t_cbo, t_accwe, t_extwe, t_cbwe;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tiny_processor dut (
    .clk(clk), .reset(reset), .start_address(start_address),
    .acc_out(acc_out), .pc(pc), .ir_out(ir_out),
    .alu_enable_out(alu_enable_out), .reg_write_out(reg_write_out),
    .alu_opcode_out(alu_opcode_out), .instruction_out(instruction_out),
    .result_out(result_out), .ext_out(ext_out),
    .reg_data_out(reg_data_out), .cb_out(cb_out)
  );

  tiny_alu u_alu (
    .acc(t_acc), .operand(t_opd), .opcode(t_op), .subcode(t_sub), .cb_in(t_cbi),
    .result(t_res), .ext_hi(t_ext), .cb_new(t_cbo),
    .acc_we(t_accwe), .ext_we(t_extwe), .cb_we(t_cbwe)
  );

  // Instruction-level model state
  int m_rom [16] = '{8'h93, 8'h15, 8'h1F, 8'h86, 8'hA7, 8'hFF, 8'h11, 8'hB0,
                     0, 0, 0, 0, 0, 0, 0, 0};
  int m_reg [16];
  int m_pc, m_acc, m_ext, m_cb, m_ret;

  typedef struct {
    logic [3:0] op; logic [3:0] sub; logic [7:0] a; logic [7:0] b; logic ci;
    logic [7:0] r; logic [7:0] e; logic co;
  } alu_vec_t;

  typedef struct { int pc; int acc; int cb; int ir; int rd; } trace_t;

  alu_vec_t vecs [18];
  trace_t   trace [7];

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ref_alu(input int op, input int sub, input int a, input int b, input int c,
                         output int r, output int e, output int co);
    r = a; e = 0; co = c;
    case (op)
      0: case (sub)
           1: r = (a * 2) % 256;
           2: r = a / 2;
           3: r = a / 2 + (a % 2) * 128;
           4: r = (a * 2) % 256 + a / 128;
           5: r = a / 2 + ((a >= 128) ? 128 : 0);
           6: begin r = (a + 1) % 256; co = (a == 255) ? 1 : 0; end
           7: begin r = (a + 255) % 256; co = (a == 0) ? 1 : 0; end
           default: r = a;
         endcase
      1: begin r = (a + b) % 256; co = (a + b > 255) ? 1 : 0; end
      2: begin r = (a - b + 256) % 256; co = (a < b) ? 1 : 0; end
      3: begin r = (a * b) % 256; e = (a * b) / 256; end
      5: r = a ^ b;
      6: co = (a < b) ? 1 : 0;
      7: r = a & b;
      default: r = a;
    endcase
  endtask

  task automatic model_reset(input int sa);
    m_pc = sa; m_acc = 0; m_ext = 0; m_cb = 0; m_ret = 0;
    for (int i = 0; i < 16; i++) m_reg[i] = i * 17;
  endtask

  task automatic model_step();
    int ins, op, x, nxt, r, e, co;
    ins = m_rom[m_pc];
    op  = ins / 16;
    x   = ins % 16;
    if (ins == 255) return;
    nxt = (m_pc + 1) % 16;
    if (op < 8) begin
      ref_alu(op, x, m_acc, m_reg[x], m_cb, r, e, co);
      if ((op == 0 && x >= 1 && x <= 7) || op == 1 || op == 2 || op == 3 || op == 5 || op == 7)
        m_acc = r;
      if ((op == 0 && x >= 6 && x <= 7) || op == 1 || op == 2 || op == 6) m_cb = co;
      if (op == 3) m_ext = e;
    end else if (op == 8) begin
      if (m_cb == 1) begin m_ret = nxt; nxt = x; end
    end else if (op == 9) begin
      m_acc = m_reg[x];
    end else if (op == 10) begin
      m_reg[x] = m_acc;
    end else if (op == 11) begin
      nxt = m_ret;
    end
    m_pc = nxt;
  endtask

  task automatic do_reset(input logic [3:0] sa);
    reset = 1'b1;
    start_address = sa;
    tick();
    reset = 1'b0;
  endtask

  initial begin
    int r, e, co, sa;
    reset = 1'b1;
    start_address = 4'd0;
    t_acc = 8'h00; t_opd = 8'h00; t_op = 4'h0; t_sub = 4'h0; t_cbi = 1'b0;

    vecs[0]  = '{4'h3, 4'h0, 8'h33, 8'hFF, 1'b0, 8'hCD, 8'h32, 1'b0};
    vecs[1]  = '{4'h1, 4'h0, 8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 1'b1};
    vecs[2]  = '{4'h2, 4'h0, 8'h10, 8'h20, 1'b0, 8'hF0, 8'h00, 1'b1};
    vecs[3]  = '{4'h2, 4'h0, 8'h20, 8'h10, 1'b1, 8'h10, 8'h00, 1'b0};
    vecs[4]  = '{4'h6, 4'h0, 8'h05, 8'h09, 1'b0, 8'h05, 8'h00, 1'b1};
    vecs[5]  = '{4'h6, 4'h0, 8'h09, 8'h09, 1'b1, 8'h09, 8'h00, 1'b0};
    vecs[6]  = '{4'h5, 4'h0, 8'hF0, 8'h3C, 1'b1, 8'hCC, 8'h00, 1'b1};
    vecs[7]  = '{4'h7, 4'h0, 8'hF0, 8'h3C, 1'b0, 8'h30, 8'h00, 1'b0};
    vecs[8]  = '{4'h0, 4'h1, 8'h81, 8'h00, 1'b0, 8'h02, 8'h00, 1'b0};
    vecs[9]  = '{4'h0, 4'h2, 8'h81, 8'h00, 1'b0, 8'h40, 8'h00, 1'b0};
    vecs[10] = '{4'h0, 4'h3, 8'h81, 8'h00, 1'b0, 8'hC0, 8'h00, 1'b0};
    vecs[11] = '{4'h0, 4'h4, 8'h81, 8'h00, 1'b0, 8'h03, 8'h00, 1'b0};
    vecs[12] = '{4'h0, 4'h5, 8'h81, 8'h00, 1'b0, 8'hC0, 8'h00, 1'b0};
    vecs[13] = '{4'h0, 4'h5, 8'h41, 8'h00, 1'b1, 8'h20, 8'h00, 1'b1};
    vecs[14] = '{4'h0, 4'h6, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, 1'b1};
    vecs[15] = '{4'h0, 4'h7, 8'h00, 8'h00, 1'b0, 8'hFF, 8'h00, 1'b1};
    vecs[16] = '{4'h0, 4'h7, 8'h01, 8'h00, 1'b1, 8'h00, 8'h00, 1'b0};
    vecs[17] = '{4'h4, 4'h0, 8'h5A, 8'h11, 1'b1, 8'h5A, 8'h00, 1'b1};

    trace[0] = '{1, 'h33, 0, 'h15, 'h55};
    trace[1] = '{2, 'h88, 0, 'h1F, 'hFF};
    trace[2] = '{3, 'h87, 1, 'h86, 'h66};
    trace[3] = '{6, 'h87, 1, 'h11, 'h11};
    trace[4] = '{7, 'h98, 0, 'hB0, 'h00};
    trace[5] = '{4, 'h98, 0, 'hA7, 'h77};
    trace[6] = '{5, 'h98, 0, 'hFF, 'hFF};

    // ALU vector table
    for (int i = 0; i < 18; i++) begin
      t_op = vecs[i].op; t_sub = vecs[i].sub; t_acc = vecs[i].a; t_opd = vecs[i].b; t_cbi = vecs[i].ci;
      #1;
      check($sformatf("alu_vec%0d_result", i), t_res, vecs[i].r);
      check($sformatf("alu_vec%0d_cb", i), t_cbo, vecs[i].co);
      if (vecs[i].op == 4'h3) check($sformatf("alu_vec%0d_ext", i), t_ext, vecs[i].e);
    end

    // Randomized ALU against the reference arithmetic
    for (int i = 0; i < 200; i++) begin
      t_op  = 4'($urandom_range(0, 7));
      t_sub = 4'($urandom_range(0, 7));
      t_acc = 8'($urandom_range(0, 255));
      t_opd = 8'($urandom_range(0, 255));
      t_cbi = 1'($urandom_range(0, 1));
      #1;
      ref_alu(int'(t_op), int'(t_sub), int'(t_acc), int'(t_opd), int'(t_cbi), r, e, co);
      check("alu_rand_result", t_res, r);
      check("alu_rand_cb", t_cbo, co);
      if (t_op == 4'h3) check("alu_rand_ext", t_ext, e);
    end

    // Reset state
    do_reset(4'd0);
    check("rst_pc", pc, 0);
    check("rst_acc", acc_out, 0);
    check("rst_cb", cb_out, 0);
    check("rst_ext", ext_out, 0);
    check("rst_instr", instruction_out, 0);
    check("rst_ir", ir_out, 'h93);
    check("rst_regdata", reg_data_out, 'h33);
    check("rst_alu_en", alu_enable_out, 0);
    check("rst_result", result_out, 0);

    // Default program trace
    for (int i = 0; i < 7; i++) begin
      tick();
      check($sformatf("trace%0d_pc", i), pc, trace[i].pc);
      check($sformatf("trace%0d_acc", i), acc_out, trace[i].acc);
      check($sformatf("trace%0d_cb", i), cb_out, trace[i].cb);
      check($sformatf("trace%0d_ir", i), ir_out, trace[i].ir);
      check($sformatf("trace%0d_regdata", i), reg_data_out, trace[i].rd);
      if (i == 0) check("trace_instr_out", instruction_out, 'h93);
      if (i == 1) begin
        check("trace_alu_en", alu_enable_out, 1);
        check("trace_alu_opcode", alu_opcode_out, 1);
        check("trace_result", result_out, 'h87);
      end
      if (i == 5) check("trace_reg_write", reg_write_out, 1);
    end
    check("final_acc", acc_out, 8'b10011000);
    check("final_pc", pc, 4'b0101);

    // Halt hold
    for (int i = 0; i < 10; i++) begin
      tick();
      check("halt_pc", pc, 5);
      check("halt_acc", acc_out, 'h98);
      check("halt_cb", cb_out, 0);
      check("halt_ext", ext_out, 0);
    end

    // Reset mid-program at pc=6, restart at 2; BR at 3 is then not taken
    do_reset(4'd0);
    for (int i = 0; i < 4; i++) tick();
    check("mid_pc_before", pc, 6);
    do_reset(4'd2);
    check("mid_pc", pc, 2);
    check("mid_acc", acc_out, 0);
    check("mid_cb", cb_out, 0);
    tick();
    check("mid_step_acc", acc_out, 'hFF);
    check("mid_step_cb", cb_out, 0);
    tick();
    check("br_not_taken_pc", pc, 4);
    check("mid_r7", reg_data_out, 'h77);
    tick();
    check("mid_halt_pc", pc, 5);

    // PC wrap through the NOP region
    do_reset(4'd8);
    for (int i = 9; i <= 16; i++) begin
      tick();
      check("wrap_pc", pc, i % 16);
      check("wrap_acc", acc_out, 0);
    end

    // Randomized start addresses against the instruction-level model
    for (int run = 0; run < 8; run++) begin
      sa = $urandom_range(0, 15);
      do_reset(4'(sa));
      model_reset(sa);
      for (int c = 0; c < 12; c++) begin
        tick();
        model_step();
        check("rand_pc", pc, m_pc);
        check("rand_acc", acc_out, m_acc);
        check("rand_cb", cb_out, m_cb);
        check("rand_ext", ext_out, m_ext);
        check("rand_ir", ir_out, m_rom[m_pc]);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tiny_processor.md
# tiny_processor

Single-cycle 8-bit accumulator processor with an internal 16×8 instruction ROM, a 16×8 register file, a carry/borrow flag (CB), an extension register (EXT) and a one-level return-address register. It executes one instruction per clock from a 4-bit program counter and stops on HLT. It is the top-level compute block; all architectural state and decode signals are exported for debug and waveform inspection.

## Interface
- No parameters.
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start_address  in  4  PC load value on reset
- acc_out  out  8  accumulator
- pc  out  4  program counter
- ir_out  out  8  ROM[pc], the instruction being decoded this cycle (combinational)
- alu_enable_out  out  1  current instruction is an ALU op (opcode 0000–0111)
- reg_write_out  out  1  current instruction writes the register file
- alu_opcode_out  out  8  {4'b0, ir[7:4]} when alu_enable_out, else 0
- instruction_out  out  8  last executed instruction (registered)
- result_out  out  8  ALU result low byte for the current instruction (combinational; 0 if not ALU)
- ext_out  out  8  EXT register
- reg_data_out  out  8  R[ir[3:0]] (combinational)
- cb_out  out  1  carry/borrow flag

## Operation
- Format: ir[7:4] opcode, ir[3:0] = x (register index or branch target).
- 0000_0001 LSL ACC; 0000_0010 LSR; 0000_0011 rotate right; 0000_0100 rotate left; 0000_0101 ASR; 0000_0110 INC (CB=carry out); 0000_0111 DEC (CB=borrow); 0000_0000 and other 0000 codes: NOP.
- 0001 ADD: {CB,ACC} = ACC + R[x]. 0010 SUB: ACC = ACC − R[x], CB = borrow. 0011 MUL: {EXT,ACC} = ACC × R[x]. 0101 XOR, 0111 AND: ACC op R[x], CB unchanged. 0110 CMP: CB = (ACC < R[x]), ACC unchanged.
- 1000 BR x: if CB=1, RET_REG ← pc+1, pc ← x; else pc+1.
- 1001 MOV ACC,R[x]; 1010 MOV R[x],ACC (reg_write_out=1).
- 1011 RET: pc ← RET_REG.
- 1111_1111 HLT: no state changes, pc holds; only reset exits.
- 0100, 1100–1110, other 1111 codes: NOP.
- All arithmetic unsigned 8-bit, truncated; pc increments modulo 16 (15 → 0).
- Register file reset contents: R[i] = {i,i} (R0=0x00, R3=0x33, R15=0xFF).
- Default ROM: 0:0x93 1:0x15 2:0x1F 3:0x86 4:0xA7 5:0xFF 6:0x11 7:0xB0, 8–15: 0x00.

## Timing
- All state updates on rising clk; one instruction per cycle, no stalls.
- Reset (sync, priority over everything, mid-program included): pc ← start_address, ACC/EXT/CB/RET_REG/instruction_out ← 0, register file ← init values. Combinational outputs then reflect ROM[start_address].
- Decode outputs are valid the same cycle pc changes; results visible on acc_out/cb_out the next cycle.
- BR followed by RET with no intervening BR returns to BR address+1; a second BR overwrites RET_REG (no stack).

## Structure
- Package tiny_processor_pkg: opcode localparams, instruction-field widths, default ROM and register init values.
- Sub-module tiny_alu: combinational, inputs ACC, operand, opcode/subcode, CB; outputs result, EXT high byte, new CB, write enables. Top holds pc, ROM, register file, ACC/EXT/CB/RET_REG.

## Test plan
- Reset with start_address=0, run 20 cycles of default program -> trace ACC 0x33, 0x88, 0x87 (CB=1), branch to 6, 0x98 (CB=0), RET to 4, R7=0x98, halt at pc=5; final acc_out=8'b10011000, pc=4'b0101.
- HLT hold: after halt, 10 more cycles -> pc, acc_out, cb_out, ext_out unchanged.
- BR not taken: CB=0 at BR -> pc increments, RET_REG unchanged.
- MUL: ACC=0x33, MUL R15 -> ACC=0xCD, EXT=0x32.
- Reset mid-program (at pc=6) with start_address=2 -> next cycle pc=2, ACC=0, CB=0, R7=0x77.
- PC wrap: start_address=8 (NOPs) -> pc 8…15 then 0.
